// File: rtl/kbd_pkg.sv
// kbd_pkg: shared types, constants and slot-set helpers for the
// keycode event decoder (eight 8-bit HID slots per snapshot).
package kbd_pkg;

    localparam int NUM_SLOTS = 8;

    typedef logic [7:0] keycode_t;
    typedef keycode_t [NUM_SLOTS-1:0] keyset_t;

    typedef struct packed {
        keycode_t code;
        logic     press;
    } kbd_event_t;

    localparam keycode_t KC_NONE         = 8'h00;
    localparam keycode_t KC_ERR_ROLLOVER = 8'h01;
    localparam keycode_t KC_POST_FAIL    = 8'h02;
    localparam keycode_t KC_ERR_UNDEF    = 8'h03;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SCAN_REL = 2'd1,
        ST_SCAN_PRS = 2'd2,
        ST_COMMIT   = 2'd3
    } kbd_state_e;

    // True when key k sits in any slot of s.
    function automatic logic in_set(input keyset_t s, input keycode_t k);
        logic r;
        r = 1'b0;
        for (int j = 0; j < NUM_SLOTS; j++)
            if (s[j] == k) r = 1'b1;
        return r;
    endfunction

    // True when slot i repeats a key already seen in a lower slot.
    function automatic logic dup_below(input keyset_t s, input logic [2:0] i);
        logic r;
        r = 1'b0;
        for (int j = 0; j < NUM_SLOTS; j++)
            if (j < int'(i) && s[j] == s[i]) r = 1'b1;
        return r;
    endfunction

    function automatic logic has_err(input keyset_t s);
        logic r;
        r = 1'b0;
        for (int j = 0; j < NUM_SLOTS; j++)
            if (s[j] == KC_ERR_ROLLOVER || s[j] == KC_POST_FAIL ||
                s[j] == KC_ERR_UNDEF)
                r = 1'b1;
        return r;
    endfunction

    function automatic logic [3:0] count_distinct(input keyset_t s);
        logic [3:0] n;
        n = 4'd0;
        for (int j = 0; j < NUM_SLOTS; j++)
            if (s[j] != KC_NONE && !dup_below(s, 3'(j)))
                n = n + 4'd1;
        return n;
    endfunction

endpackage

// File: rtl/kbd_event_fifo.sv
// kbd_event_fifo: synchronous FIFO of press/release events.
// Ports: clk, reset (async high); i_push/i_code/i_press in, o_full;
// i_pop, o_empty, o_code/o_press = head entry (held until popped).
module kbd_event_fifo
    import kbd_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_push,
    input  logic [7:0] i_code,
    input  logic       i_press,
    output logic       o_full,
    input  logic       i_pop,
    output logic       o_empty,
    output logic [7:0] o_code,
    output logic       o_press
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    kbd_event_t    r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic          w_pop;
    logic          w_push;
    kbd_event_t    w_head;

    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == FULL_CNT);
    assign w_pop   = i_pop && !o_empty;
    // A pop frees the slot this cycle, so a push into a full FIFO is kept.
    assign w_push  = i_push && (!o_full || w_pop);
    assign w_head  = r_mem[r_rd];
    assign o_code  = w_head.code;
    assign o_press = w_head.press;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            for (int k = 0; k < DEPTH; k++)
                r_mem[k] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= '{code: i_code, press: i_press};
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop)
                r_rd <= r_rd + AW'(1);
            if (w_push && !w_pop)
                r_cnt <= r_cnt + (AW+1)'(1);
            else if (w_pop && !w_push)
                r_cnt <= r_cnt - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/keycode_event_decoder.sv
// keycode_event_decoder: turns debounced HID keycode snapshots into an
// ordered release-then-press event stream.
// Ports: clk, reset (async high); keycode0/1 = slots 0..7;
// evt_valid/evt_ready/evt_code/evt_press = event stream;
// held_count, overflow (sticky, clear_overflow), err_rollover pulse.
module keycode_event_decoder
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH    = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] keycode0,
    input  logic [31:0] keycode1,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [7:0]  evt_code,
    output logic        evt_press,
    output logic [3:0]  held_count,
    output logic        overflow,
    input  logic        clear_overflow,
    output logic        err_rollover
);
    localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES - 1);

    keyset_t    w_sample;
    keyset_t    r_raw;
    keyset_t    r_cur;
    keyset_t    r_prev;
    logic [7:0] r_stab;
    logic       r_err_seen;
    logic       r_err;
    logic       r_ovf;
    logic [2:0] r_idx;
    logic [3:0] r_held;
    kbd_state_e r_state;
    kbd_state_e w_next;
    logic       w_changed;
    logic       w_stable;
    logic       w_start;
    logic       w_err_hit;
    logic       w_go;
    keyset_t    w_scan_a;
    keyset_t    w_scan_b;
    keycode_t   w_key;
    logic       w_push;
    logic       w_press;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic       w_drop;

    assign w_sample  = {keycode1, keycode0};
    assign w_changed = (w_sample != r_raw);
    assign w_stable  = (r_stab == STAB_MAX);
    // r_err_seen keeps one bad snapshot from pulsing every cycle.
    assign w_start   = (r_state == ST_IDLE) && w_stable &&
                       (r_raw != r_prev) && !r_err_seen;
    assign w_err_hit = w_start && has_err(r_raw);
    assign w_go      = w_start && !has_err(r_raw);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_raw      <= '0;
            r_stab     <= '0;
            r_err_seen <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_raw <= w_sample;
            r_err <= w_err_hit;
            if (w_changed) begin
                r_stab     <= '0;
                r_err_seen <= 1'b0;
            end else begin
                if (r_stab != STAB_MAX)
                    r_stab <= r_stab + 8'd1;
                if (w_err_hit)
                    r_err_seen <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:     if (w_go) w_next = ST_SCAN_REL;
            ST_SCAN_REL: if (r_idx == 3'd7) w_next = ST_SCAN_PRS;
            ST_SCAN_PRS: if (r_idx == 3'd7) w_next = ST_COMMIT;
            ST_COMMIT:   w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    // Release phase walks prev against cur; press phase the reverse.
    always_comb begin
        w_scan_a = r_prev;
        w_scan_b = r_cur;
        w_press  = 1'b0;
        if (r_state == ST_SCAN_PRS) begin
            w_scan_a = r_cur;
            w_scan_b = r_prev;
            w_press  = 1'b1;
        end
        w_key  = w_scan_a[r_idx];
        w_push = (r_state == ST_SCAN_REL || r_state == ST_SCAN_PRS) &&
                 (w_key != KC_NONE) && !in_set(w_scan_b, w_key) &&
                 !dup_below(w_scan_a, r_idx);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cur  <= '0;
            r_prev <= '0;
            r_idx  <= '0;
            r_held <= '0;
        end else begin
            if (w_go) begin
                r_cur <= r_raw;
                r_idx <= '0;
            end
            if (r_state == ST_SCAN_REL || r_state == ST_SCAN_PRS)
                r_idx <= r_idx + 3'd1;
            if (r_state == ST_COMMIT) begin
                r_prev <= r_cur;
                r_held <= count_distinct(r_cur);
            end
        end
    end

    assign evt_valid = !w_empty;
    assign w_pop     = evt_valid && evt_ready;
    assign w_drop    = w_push && w_full && !w_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_ovf <= 1'b0;
        else if (w_drop)
            r_ovf <= 1'b1;
        else if (clear_overflow)
            r_ovf <= 1'b0;
    end

    kbd_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_code  (w_key),
        .i_press (w_press),
        .o_full  (w_full),
        .i_pop   (w_pop),
        .o_empty (w_empty),
        .o_code  (evt_code),
        .o_press (evt_press)
    );

    assign held_count   = r_held;
    assign overflow     = r_ovf;
    assign err_rollover = r_err;

endmodule

// File: doc/keycode_event_decoder.md
Name: keycode_event_decoder

Overview:
Converts the level-style USB HID keycode snapshots written by the MicroBlaze GPIO (two 32-bit words, eight 8-bit slots) into an ordered stream of discrete press and release events. Game logic, including OBB spawn and impulse control, consumes this stream through a valid/ready interface instead of polling raw keycodes.
- Sits between mb_block's keycode GPIO outputs and the game-control logic.
- Runs entirely in the 100 MHz Clk domain.

Parameters:
- FIFO_DEPTH, 8: event FIFO entries; must be a power of 2 and at least 2.
- STABLE_CYCLES, 4: consecutive identical input samples required before a snapshot is accepted (range 1..255).

Ports:
- clk, in, 1: system clock (top-level Clk, 100 MHz).
- reset, in, 1: asynchronous, active-high reset.
- keycode0, in, 32: slots 0..3; slot0 = [7:0], slot3 = [31:24].
- keycode1, in, 32: slots 4..7; slot4 = [7:0], slot7 = [31:24].
- evt_valid, out, 1: FIFO head holds a valid event.
- evt_ready, in, 1: consumer accepts the head event.
- evt_code, out, 8: keycode of the head event.
- evt_press, out, 1: 1 = press, 0 = release.
- held_count, out, 4: number of distinct nonzero keys in the committed set (0..8).
- overflow, out, 1: sticky; an event was dropped because the FIFO was full.
- clear_overflow, in, 1: clears overflow, synchronous.
- err_rollover, out, 1: one-cycle pulse when a snapshot is discarded as an HID error.

Behaviour:
- Reset values:
  - evt_valid=0, evt_code=0, evt_press=0, held_count=0, overflow=0, err_rollover=0.
  - FIFO empty, prev_set all 0x00, FSM in IDLE, stability counter 0.
- Input sampling:
  - raw register captures {keycode1, keycode0} every cycle.
  - stab_cnt: set to 0 if raw differs from the previous raw; otherwise increments, saturating at STABLE_CYCLES-1.
  - A snapshot is "stable" when stab_cnt == STABLE_CYCLES-1.
- FSM states: IDLE, SCAN_REL, SCAN_PRS, COMMIT.
- IDLE:
  - If stable and raw != prev_set: latch cur_set <= raw and set slot index i=0.
  - If any cur slot is 0x01, 0x02 or 0x03 (HID error codes): pulse err_rollover, stay in IDLE, leave prev_set unchanged. The same erroneous snapshot never re-pulses until raw changes.
  - Otherwise go to SCAN_REL.
- SCAN_REL (8 cycles, i = 0..7):
  - Push release(prev[i]) iff all of: prev[i] != 0, prev[i] not present in any cur slot, and prev[i] does not equal any prev[j] for j<i (first-occurrence dedupe).
  - At i=7 go to SCAN_PRS with i=0.
- SCAN_PRS (8 cycles):
  - Push press(cur[i]) iff cur[i] != 0, cur[i] not in any prev slot, and cur[i] != cur[j] for all j<i.
  - At i=7 go to COMMIT.
- COMMIT (1 cycle): prev_set <= cur_set; held_count <= count of distinct nonzero cur slots; go to IDLE.
- Ordering: all releases precede all presses; within each phase, events appear in ascending slot order.
- Input changes during a scan are ignored. raw and stab_cnt keep running, so a change is picked up from IDLE after COMMIT.
- Latency: a push in cycle c gives evt_valid=1 in cycle c+1. Minimum from first stable sample to first event is 2 cycles; a full scan is 17 cycles.
- FIFO:
  - Pop on evt_valid & evt_ready.
  - Simultaneous push and pop when full is allowed; no drop occurs.
  - Push while full with no pop: the event is dropped and overflow <= 1.
  - If clear_overflow and a drop occur in the same cycle, overflow stays 1.
  - evt_code and evt_press hold their values while evt_valid=1 and evt_ready=0.
- Reset mid-scan: asserting reset immediately restores all reset values. The FIFO is flushed and prev_set is cleared, so keys still held re-emit press events after reset.

Decomposition:
- Package kbd_pkg:
  - keycode_t (logic [7:0]).
  - kbd_event_t struct {keycode_t code; logic press;}.
  - NUM_SLOTS=8.
  - KC_NONE=8'h00, KC_ERR_ROLLOVER=8'h01, KC_POST_FAIL=8'h02, KC_ERR_UNDEF=8'h03.
  - FSM state enum.
- Sub-module kbd_event_fifo: parameterised synchronous FIFO of kbd_event_t with push/full/pop/empty and a registered head.

Test Plan:
- Single key, ready held 1: slot0 0x00→0x04 held for 4 cycles → exactly one event {0x04, press}; held_count=1. Return to 0x00 → {0x04, release}; held_count=0.
- Swap: prev {0x04, 0x05} → new {0x05, 0x06} in slots 0/1 → events in order {0x04, rel}, {0x06, press}; no event for 0x05.
- Glitch filter with STABLE_CYCLES=4: slot2=0x1A for 3 cycles, then back to 0 → no events, FSM never leaves IDLE.
- Duplicates and rollover:
  - slot0 = slot3 = 0x2C → a single {0x2C, press}; held_count=1.
  - All slots 0x01 → err_rollover pulses once, no events, prev_set unchanged.
- Overflow with FIFO_DEPTH=4, evt_ready=0: 6 new keys pressed → first 4 presses retained in slot order, overflow=1. Drain → 4 events, evt_valid=0. clear_overflow → overflow=0.
- Reset during SCAN_PRS while keys 0x04 and 0x07 are held → all outputs reach reset values immediately. After release of reset, presses for 0x04 then 0x07 are re-emitted.
